ssc_sort_checker: RTL

- Hardware order checker placed directly downstream of ssc_wrapper.
- Triggers when the sorter's Done rises, then scans the sorted memory through the sorter's debug read port: Debug_Addr/Debug_En out, Read_Data in.
- Pipelined adjacent-pair compare confirms the contents are strictly descending.
- Reports pass/fail, violation count and first failing address, so silicon and regressions need no software scan.

---
 rtl/ssc_sort_checker_if.sv | 43 ++++
 rtl/ssc_sort_checker.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ssc_sort_checker_if.sv
// Handshake/bus bundle between the sorter debug port and ssc_sort_checker.
// master = sorter/memory side, slave = checker side.
interface ssc_sort_checker_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              Sort_Done;
    logic [ADDR_W-1:0] Debug_Addr;
    logic              Debug_En;
    logic [DATA_W-1:0] Read_Data;
    logic              Chk_Busy;
    logic              Chk_Done;
    logic              Chk_Pass;
    logic [ADDR_W-1:0] Err_Count;
    logic              First_Err_Valid;
    logic [ADDR_W-1:0] First_Err_Addr;

    modport master (
        output Sort_Done,
        output Read_Data,
        input  Debug_Addr,
        input  Debug_En,
        input  Chk_Busy,
        input  Chk_Done,
        input  Chk_Pass,
        input  Err_Count,
        input  First_Err_Valid,
        input  First_Err_Addr
    );

    modport slave (
        input  Sort_Done,
        input  Read_Data,
        output Debug_Addr,
        output Debug_En,
        output Chk_Busy,
        output Chk_Done,
        output Chk_Pass,
        output Err_Count,
        output First_Err_Valid,
        output First_Err_Addr
    );
endinterface

// File: rtl/ssc_sort_checker.sv
// Scans sorter memory after Done rises and checks strictly descending order.
// Optional macro SSC_CHK_ALLOW_EQUAL_EN: equal neighbours are accepted.
module ssc_sort_checker #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input logic               Clk,
    input logic               Rst_N,
    ssc_sort_checker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    logic              sd_q;
    logic [ADDR_W-1:0] addr_q;
    logic              en_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [ADDR_W-1:0] err_q;
    logic [ADDR_W-1:0] err_d;
    logic              fev_q;
    logic [ADDR_W-1:0] fea_q;
    logic [DATA_W-1:0] prev_q;
    logic [RD_LAT-1:0] vld_q;
    logic [ADDR_W-1:0] idx_q [RD_LAT];

    logic              trig;
    logic              smp;
    logic [ADDR_W-1:0] sidx;
    logic              bad;
    logic              viol;
    logic              last;

    // Edge detect, sample alignment, pair rule and saturating count.
    always_comb begin
        trig = (state_q == IDLE) && bus.Sort_Done && !sd_q;
        smp  = vld_q[RD_LAT-1];
        sidx = idx_q[RD_LAT-1];
`ifdef SSC_CHK_ALLOW_EQUAL_EN
        bad  = bus.Read_Data > prev_q;
`else
        bad  = bus.Read_Data >= prev_q;
`endif
        viol = smp && (sidx != '0) && bad;
        last = smp && (sidx == LAST);
        err_d = err_q;
        if (viol && (err_q != '1)) begin
            err_d = err_q + 1'b1;
        end
    end

    // Scan FSM with registered outputs and read-latency tracking.
    always_ff @(posedge Clk) begin
        if (!Rst_N) begin
            state_q <= IDLE;
            sd_q    <= 1'b0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fea_q   <= '0;
            prev_q  <= '0;
            vld_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            sd_q     <= bus.Sort_Done;
            vld_q[0] <= en_q;
            idx_q[0] <= addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
            if (smp) begin
                prev_q <= bus.Read_Data;
            end
            err_q <= err_d;
            if (viol && !fev_q) begin
                fev_q <= 1'b1;
                fea_q <= sidx;
            end
            unique case (state_q)
                IDLE: begin
                    if (trig) begin
                        state_q <= ISSUE;
                        addr_q  <= '0;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        fev_q   <= 1'b0;
                        fea_q   <= '0;
                    end
                end
                ISSUE: begin
                    if (addr_q == LAST) begin
                        state_q <= DRAIN;
                        addr_q  <= '0;
                        en_q    <= 1'b0;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.Debug_Addr      = addr_q;
    assign bus.Debug_En        = en_q;
    assign bus.Chk_Busy        = busy_q;
    assign bus.Chk_Done        = done_q;
    assign bus.Chk_Pass        = pass_q;
    assign bus.Err_Count       = err_q;
    assign bus.First_Err_Valid = fev_q;
    assign bus.First_Err_Addr  = fea_q;
endmodule
